mux_sync_gap: RTL and testbench

Multi-channel registered signal multiplexer for routing external trigger/clock-like inputs to NUM_OUT independent outputs.
Each output channel selects one of NUM_IN synchronized inputs, with an optional per-channel polarity inversion.
Selection changes are applied glitch-free: the output is parked at its idle level for a programmable guard gap before the new source connects.
Sits between the input pin synchronizers and the timing/trigger logic; control comes from a register bank.

---
 rtl/mux_sync_gap.sv | 125 ++++++++++++
 tb/tb_mux_sync_gap.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sync_gap.sv
// Multi-channel registered trigger multiplexer: synchronizes NUM_IN asynchronous inputs and
// routes one of them (optionally inverted) to each output, parking at the idle level on reselection.
module mux_sync_gap #(
    parameter int CTRL_BITS   = 2,
    parameter int NUM_IN      = 4,
    parameter int NUM_OUT     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_OUT*CTRL_BITS-1:0]   ctrl,
    input  logic [NUM_OUT-1:0]             inv,
    input  logic                           ctrl_load,
    input  logic [NUM_IN-1:0]              in,
    output logic [NUM_OUT-1:0]             out,
    output logic [NUM_OUT-1:0]             busy
);

    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_GAP = 1'b1;

    logic [NUM_IN-1:0] in_s;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    if (SYNC_STAGES == 0) begin : g_bypass
        assign in_s = in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync_q;

        // NOTE: non-blocking assignments let every stage sample its predecessor's old value,
        // so the chain really is SYNC_STAGES flops deep regardless of statement order.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= in;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[s] <= sync_q[s-1];
                end
            end
        end

        assign in_s = sync_q[SYNC_STAGES-1];
    end

    // ------------------------------------------------------------------
    // Per-channel selection FSM
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < NUM_OUT; ch++) begin : g_ch
        logic [CTRL_BITS-1:0] req_sel;
        logic                 req_inv;
        logic [CTRL_BITS-1:0] sel_q, nxt_sel;
        logic                 inv_q, nxt_inv;
        logic [0:0]           state_q, nxt_state;
        logic [CNT_W-1:0]     cnt_q, nxt_cnt;
        logic                 change;
        logic                 src;
        logic                 out_q, busy_q;

        assign req_sel = ctrl[ch*CTRL_BITS +: CTRL_BITS];
        assign req_inv = inv[ch];

        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        always_comb begin
            nxt_sel   = sel_q;
            nxt_inv   = inv_q;
            nxt_state = state_q;
            nxt_cnt   = cnt_q;
            change    = ctrl_load && ({req_sel, req_inv} != {sel_q, inv_q});

            if (change) begin
                nxt_sel = req_sel;
                nxt_inv = req_inv;
                if (GAP_CYCLES > 0) begin
                    nxt_state = ST_GAP;
                    nxt_cnt   = GAP_LOAD;
                end
            end else if (state_q == ST_GAP) begin
                if (cnt_q == '0) begin
                    nxt_state = ST_RUN;
                end else begin
                    nxt_cnt = cnt_q - CNT_W'(1);
                end
            end
        end

        // Out-of-range selects fall through to 0, so the output shows the idle level.
        always_comb begin
            src = 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (nxt_sel == CTRL_BITS'(i)) begin
                    src = in_s[i];
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sel_q   <= '0;
                inv_q   <= 1'b0;
                state_q <= ST_RUN;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                sel_q   <= nxt_sel;
                inv_q   <= nxt_inv;
                state_q <= nxt_state;
                cnt_q   <= nxt_cnt;
                out_q   <= (nxt_state == ST_GAP) ? nxt_inv : (src ^ nxt_inv);
                busy_q  <= (nxt_state == ST_GAP);
            end
        end

        assign out[ch]  = out_q;
        assign busy[ch] = busy_q;
    end

endmodule

// File: tb/tb_mux_sync_gap.sv
// Directed bench for mux_sync_gap: hand sequences on the default configuration and a
// vector table on a 3-input, unsynchronized, zero-gap instance.
module tb_mux_sync_gap;

    logic       clock;
    logic       reset;

    // Instance A: defaults (4 inputs, 2 sync stages, 4-cycle gap)
    logic [3:0] a_ctrl;
    logic [1:0] a_inv;
    logic       a_load;
    logic [3:0] a_in;
    logic [1:0] a_out, a_busy;

    // Instance B: 3 inputs, no synchronizer, no gap
    logic [3:0] b_ctrl;
    logic [1:0] b_inv;
    logic       b_load;
    logic [2:0] b_in;
    logic [1:0] b_out, b_busy;

    int n_vec = 0;
    int n_bad = 0;

    mux_sync_gap dut_a (
        .clock     (clock),
        .reset     (reset),
        .ctrl      (a_ctrl),
        .inv       (a_inv),
        .ctrl_load (a_load),
        .in        (a_in),
        .out       (a_out),
        .busy      (a_busy)
    );

    mux_sync_gap #(
        .CTRL_BITS   (2),
        .NUM_IN      (3),
        .NUM_OUT     (2),
        .SYNC_STAGES (0),
        .GAP_CYCLES  (0)
    ) dut_b (
        .clock     (clock),
        .reset     (reset),
        .ctrl      (b_ctrl),
        .inv       (b_inv),
        .ctrl_load (b_load),
        .in        (b_in),
        .out       (b_out),
        .busy      (b_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic       load;
        logic [3:0] ctrl;
        logic [1:0] inv;
        logic [2:0] in;
        logic [1:0] exp_out;
    } vec_t;

    vec_t vecs [12];

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {out,busy} got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_a(input string name, input logic [1:0] eo, input logic [1:0] eb);
        check(name, {a_out, a_busy}, {eo, eb});
    endtask

    // Drive a one-cycle ctrl_load on instance A; returns just after the sampling edge.
    task automatic load_a(input logic [3:0] c, input logic [1:0] v);
        a_ctrl = c;
        a_inv  = v;
        a_load = 1'b1;
        step(1);
        a_load = 1'b0;
    endtask

    initial begin
        // ctrl = {sel1, sel0}; exp_out = {out1, out0}
        vecs[0]  = '{1'b0, 4'b0000, 2'b00, 3'b001, 2'b11};
        vecs[1]  = '{1'b0, 4'b0000, 2'b00, 3'b000, 2'b00};
        vecs[2]  = '{1'b1, 4'b0110, 2'b00, 3'b100, 2'b01};
        vecs[3]  = '{1'b0, 4'b0000, 2'b00, 3'b010, 2'b10};
        vecs[4]  = '{1'b1, 4'b0111, 2'b00, 3'b111, 2'b10};
        vecs[5]  = '{1'b0, 4'b0000, 2'b00, 3'b000, 2'b00};
        vecs[6]  = '{1'b0, 4'b0000, 2'b00, 3'b111, 2'b10};
        vecs[7]  = '{1'b1, 4'b0111, 2'b10, 3'b010, 2'b00};
        vecs[8]  = '{1'b0, 4'b0000, 2'b00, 3'b000, 2'b10};
        vecs[9]  = '{1'b1, 4'b1011, 2'b10, 3'b100, 2'b00};
        vecs[10] = '{1'b1, 4'b1011, 2'b11, 3'b000, 2'b11};
        vecs[11] = '{1'b1, 4'b0000, 2'b00, 3'b001, 2'b11};

        reset  = 1'b1;
        a_ctrl = 4'b0000; a_inv = 2'b00; a_load = 1'b0; a_in = 4'b1111;
        b_ctrl = 4'b0000; b_inv = 2'b00; b_load = 1'b0; b_in = 3'b000;

        // Reset holds outputs low even with inputs high and a load request
        step(1);
        chk_a("reset_c0", 2'b00, 2'b00);
        a_ctrl = 4'b0101; a_inv = 2'b11; a_load = 1'b1;
        step(1);
        chk_a("reset_c1", 2'b00, 2'b00);
        a_load = 1'b0;
        step(1);
        chk_a("reset_c2", 2'b00, 2'b00);
        reset = 1'b0;
        a_in  = 4'b0000;
        step(3);
        chk_a("post_reset", 2'b00, 2'b00);

        // Select in[1] on ch0, wait out the gap, then measure input->output latency
        load_a(4'b0001, 2'b00);
        chk_a("sel1_gap0", 2'b00, 2'b01);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk_a($sformatf("sel1_gap%0d", i), 2'b00, 2'b01);
        end
        step(1);
        chk_a("sel1_run", 2'b00, 2'b00);
        a_in = 4'b0010;
        step(2);
        chk_a("latency_t2", 2'b00, 2'b00);
        step(1);
        chk_a("latency_t3", 2'b01, 2'b00);

        // Glitch-free switch: ch0 to in[0] (=1), then to in[2] (=1)
        a_in = 4'b0101;
        step(3);
        chk_a("pre_switch", 2'b10, 2'b00);
        load_a(4'b0000, 2'b00);
        chk_a("to_in0_g0", 2'b10, 2'b01);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk_a($sformatf("to_in0_g%0d", i), 2'b10, 2'b01);
        end
        step(1);
        chk_a("to_in0_run", 2'b11, 2'b00);
        load_a(4'b0010, 2'b00);
        chk_a("to_in2_g0", 2'b10, 2'b01);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk_a($sformatf("to_in2_g%0d", i), 2'b10, 2'b01);
        end
        step(1);
        chk_a("to_in2_run", 2'b11, 2'b00);

        // Inversion on ch1 only: idle level is 1, selected input 0
        a_in = 4'b0100;
        step(3);
        chk_a("pre_inv", 2'b01, 2'b00);
        load_a(4'b0010, 2'b10);
        chk_a("inv_g0", 2'b11, 2'b10);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk_a($sformatf("inv_g%0d", i), 2'b11, 2'b10);
        end
        step(1);
        chk_a("inv_run", 2'b11, 2'b00);

        // Retrigger after 2 cycles (6 idle cycles total); same-value load mid-gap is ignored
        load_a(4'b0011, 2'b10);
        chk_a("retrig_e0", 2'b10, 2'b01);
        a_in = 4'b0110;
        step(1);
        chk_a("retrig_e1", 2'b10, 2'b01);
        load_a(4'b0001, 2'b10);
        chk_a("retrig_e2", 2'b10, 2'b01);
        step(1);
        chk_a("retrig_e3", 2'b10, 2'b01);
        load_a(4'b0001, 2'b10);
        chk_a("retrig_e4_same", 2'b10, 2'b01);
        step(1);
        chk_a("retrig_e5", 2'b10, 2'b01);
        step(1);
        chk_a("retrig_e6_run", 2'b11, 2'b00);

        // Identical load in RUN: no gap
        load_a(4'b0001, 2'b10);
        chk_a("same_run_e0", 2'b11, 2'b00);
        step(1);
        chk_a("same_run_e1", 2'b11, 2'b00);

        // Asynchronous reset two cycles into a gap
        load_a(4'b0010, 2'b10);
        chk_a("areset_gap0", 2'b10, 2'b01);
        step(1);
        chk_a("areset_gap1", 2'b10, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        chk_a("areset_no_edge", 2'b00, 2'b00);
        step(1);
        reset = 1'b0;
        a_in  = 4'b0001;
        step(3);
        chk_a("areset_sel0", 2'b11, 2'b00);

        // Instance B table: out-of-range select, zero gap, channel independence
        for (int i = 0; i < 12; i++) begin
            b_load = vecs[i].load;
            b_ctrl = vecs[i].ctrl;
            b_inv  = vecs[i].inv;
            b_in   = vecs[i].in;
            step(1);
            check($sformatf("tbl_%0d", i), {b_out, b_busy}, {vecs[i].exp_out, 2'b00});
        end
        b_load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
